// File: rtl/seq_mul_pkg.sv
// Shared definitions for the sequential shift-add MAC multiplier.
// Optional feature macro: SEQ_MUL_SIGNED_EN (two's complement operands).
`ifndef SEQ_MUL_ACC_W
// Accumulator width: full product width plus guard bits.
`define SEQ_MUL_ACC_W(w, g) ((2*(w)) + (g))
`endif

package seq_mul_pkg;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Iteration counter width; holds WIDTH-1 without wrapping.
    function automatic int count_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/seq_mul_ctrl.sv
// Control FSM for the shift-add multiplier: IDLE -> RUN (WIDTH iterations) -> DONE -> IDLE.
// Produces load/shift/last strobes plus busy/done status.
// With SEQ_MUL_SIGNED_EN defined it also flags the first (MSB-weight) iteration.
module seq_mul_ctrl
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
`ifdef SEQ_MUL_SIGNED_EN
    output logic first,
`endif
    output logic busy,
    output logic done,
    output logic load,
    output logic shift,
    output logic last
);

    localparam int CNT_W = count_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;

    // State and iteration counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Next-state, counter update and strobe decode
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        busy    = 1'b0;
        done    = 1'b0;
        load    = 1'b0;
        shift   = 1'b0;
        last    = 1'b0;
`ifdef SEQ_MUL_SIGNED_EN
        first   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    count_d = CNT_LOAD;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                busy  = 1'b1;
                shift = 1'b1;
`ifdef SEQ_MUL_SIGNED_EN
                first = (count_q == CNT_LOAD);
`endif
                // Counter stops at zero so it never wraps inside RUN
                if (count_q == '0) begin
                    last    = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/seq_mac_multiplier.sv
// Sequential MSB-first shift-add multiplier with optional accumulate into a guarded product.
// Latency start->done is WIDTH+1 edges; product only changes on DONE entry or reset.
// Optional feature macro: SEQ_MUL_SIGNED_EN adds the sign_mode port and a signed datapath.
module seq_mac_multiplier
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int GUARD = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic                                  acc_en,
`ifdef SEQ_MUL_SIGNED_EN
    input  logic                                  sign_mode,
`endif
    input  logic [WIDTH-1:0]                      a,
    input  logic [WIDTH-1:0]                      b,
    output logic                                  busy,
    output logic                                  done,
    output logic [`SEQ_MUL_ACC_W(WIDTH, GUARD)-1:0] product
);

    localparam int P_W   = 2 * WIDTH;
    localparam int ACC_W = `SEQ_MUL_ACC_W(WIDTH, GUARD);

    logic             load, shift, last;
`ifdef SEQ_MUL_SIGNED_EN
    logic             first;
    logic             sign_q, sign_d;
`endif

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             acc_en_q, acc_en_d;
    logic [P_W-1:0]   work_q, work_d;
    logic [ACC_W-1:0] product_q, product_d;

    logic [P_W-1:0]   b_ext;
    logic [P_W-1:0]   pp;
    logic [P_W-1:0]   work_step;
    logic [ACC_W-1:0] work_acc;

    seq_mul_ctrl #(
        .WIDTH (WIDTH)
    ) u_ctrl (
        .clk   (clk),
        .rst   (rst),
        .start (start),
`ifdef SEQ_MUL_SIGNED_EN
        .first (first),
`endif
        .busy  (busy),
        .done  (done),
        .load  (load),
        .shift (shift),
        .last  (last)
    );

    // Partial product, one shift-add step and extension of the finished product
    always_comb begin
        b_ext    = {{WIDTH{1'b0}}, b_q};
        pp       = '0;
        work_acc = '0;
`ifdef SEQ_MUL_SIGNED_EN
        if (sign_q) begin
            b_ext = {{WIDTH{b_q[WIDTH-1]}}, b_q};
        end
        if (a_q[WIDTH-1]) begin
            // The MSB of a two's complement multiplier carries negative weight
            pp = (sign_q && first) ? (P_W'(0) - b_ext) : b_ext;
        end
`else
        if (a_q[WIDTH-1]) begin
            pp = b_ext;
        end
`endif
        work_step = {work_q[P_W-2:0], 1'b0} + pp;
`ifdef SEQ_MUL_SIGNED_EN
        work_acc  = sign_q ? ACC_W'($signed(work_step)) : ACC_W'(work_step);
`else
        work_acc  = ACC_W'(work_step);
`endif
    end

    // Operand capture on accept, iteration in RUN, product update on the final iteration
    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        acc_en_d  = acc_en_q;
        work_d    = work_q;
        product_d = product_q;
`ifdef SEQ_MUL_SIGNED_EN
        sign_d    = sign_q;
`endif
        if (load) begin
            a_d      = a;
            b_d      = b;
            acc_en_d = acc_en;
            work_d   = '0;
`ifdef SEQ_MUL_SIGNED_EN
            sign_d   = sign_mode;
`endif
        end else if (shift) begin
            a_d    = {a_q[WIDTH-2:0], 1'b0};
            work_d = work_step;
            if (last) begin
                // Accumulation wraps modulo 2^ACC_W
                product_d = acc_en_q ? (product_q + work_acc) : work_acc;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            acc_en_q  <= 1'b0;
            work_q    <= '0;
            product_q <= '0;
`ifdef SEQ_MUL_SIGNED_EN
            sign_q    <= 1'b0;
`endif
        end else begin
            a_q       <= a_d;
            b_q       <= b_d;
            acc_en_q  <= acc_en_d;
            work_q    <= work_d;
            product_q <= product_d;
`ifdef SEQ_MUL_SIGNED_EN
            sign_q    <= sign_d;
`endif
        end
    end

    assign product = product_q;

endmodule

// File: tb/tb_seq_mac_multiplier.sv
// Self-checking bench for seq_mac_multiplier (WIDTH=8, GUARD=4, ACC_W=20).
// Expected products go into a queue at issue time; a monitor pops one per done pulse.
// Signed vectors are exercised only when SEQ_MUL_SIGNED_EN is defined.
`timescale 1ns/1ps
module tb_seq_mac_multiplier;

    localparam int W     = 8;
    localparam int ACC_W = 20;

    logic             clk    = 1'b0;
    logic             rst    = 1'b1;
    logic             start  = 1'b0;
    logic             acc_en = 1'b0;
`ifdef SEQ_MUL_SIGNED_EN
    logic             sign_mode = 1'b0;
`endif
    logic [W-1:0]     a = '0;
    logic [W-1:0]     b = '0;
    logic             busy;
    logic             done;
    logic [ACC_W-1:0] product;

    int               checks = 0;
    int               errors = 0;
    logic [ACC_W-1:0] exp_q[$];
    logic [ACC_W-1:0] mon_exp;

    seq_mac_multiplier #(
        .WIDTH (W),
        .GUARD (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .acc_en    (acc_en),
`ifdef SEQ_MUL_SIGNED_EN
        .sign_mode (sign_mode),
`endif
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .product   (product)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, want);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got product=0x%05h expected no done pulse", product);
            end else begin
                mon_exp = exp_q.pop_front();
                $display("txn product=0x%05h expected=0x%05h", product, mon_exp);
                chk("product", 32'(product), 32'(mon_exp));
            end
        end
    end

    // Issue one operation from IDLE and check latency, busy length and done width.
    // poke_i >= 0 pulses start with different operands during RUN.
    task automatic run_op(input string tag, input logic [W-1:0] aa, input logic [W-1:0] bb,
                          input logic acc, input logic sgn, input logic [ACC_W-1:0] want,
                          input int poke_i);
        int busy_cnt;
        int done_cnt;
        int lat;
        a      = aa;
        b      = bb;
        acc_en = acc;
`ifdef SEQ_MUL_SIGNED_EN
        sign_mode = sgn;
`else
        if (sgn) $display("note: signed request ignored in unsigned build");
`endif
        start  = 1'b1;
        exp_q.push_back(want);
        @(posedge clk); #1;
        start    = 1'b0;
        busy_cnt = 0;
        done_cnt = 0;
        lat      = -1;
        for (int i = 0; i < W + 4; i++) begin
            if (i == poke_i) begin
                start  = 1'b1;
                a      = 8'd7;
                b      = 8'd9;
                acc_en = ~acc;
            end else if (i == poke_i + 1) begin
                start = 1'b0;
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (lat < 0) lat = i;
            end
            @(posedge clk); #1;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(W));
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(W + 1));
        chk({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_seen;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_product", 32'(product), 32'd0);
        rst = 1'b0;

        // 1: full-scale unsigned product
        run_op("t1", 8'd255, 8'd255, 1'b0, 1'b0, 20'd65025, -1);

        // 2: overwrite then accumulate
        run_op("t2a", 8'd3, 8'd4, 1'b0, 1'b0, 20'd12, -1);
        run_op("t2b", 8'd5, 8'd6, 1'b1, 1'b0, 20'd42, -1);

        // 3: start during RUN is ignored
        run_op("t3", 8'd255, 8'd255, 1'b0, 1'b0, 20'd65025, 3);

        // 4: 17 accumulations of 255*255 wrap modulo 2^20
        for (int k = 1; k <= 17; k++) begin
            run_op("t4", 8'd255, 8'd255, (k > 1), 1'b0, ACC_W'(65025 * k), -1);
        end
        chk("t4_final", 32'(product), 32'd56849);

        // 5: reset at edge k+4 aborts a 7*9 op with no done pulse
        a      = 8'd7;
        b      = 8'd9;
        acc_en = 1'b0;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        chk("t5_product", 32'(product), 32'd0);
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < W + 4; i++) begin
            if (done) done_seen++;
            @(posedge clk); #1;
        end
        chk("t5_no_done", 32'(done_seen), 32'd0);
        run_op("t5b", 8'd2, 8'd3, 1'b1, 1'b0, 20'd6, -1);

`ifdef SEQ_MUL_SIGNED_EN
        // 6: signed operands
        run_op("t6a", 8'h80, 8'h80, 1'b0, 1'b1, 20'h04000, -1);
        run_op("t6b", 8'hFF, 8'd5, 1'b0, 1'b1, 20'hFFFFB, -1);
        run_op("t6c", 8'd3, 8'hFE, 1'b1, 1'b1, 20'hFFFF5, -1);
        run_op("t6d", 8'hFF, 8'hFF, 1'b0, 1'b0, 20'd65025, -1);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
